// File: rtl/sr_cmd_arbiter.sv
// sr_cmd_arbiter: round-robin arbiter/sequencer sharing a bank of SR
// flip-flops between NREQ requesters. Drives at most one S or R bit for one
// cycle per operation and never S=R=1.
// Optional feature macro: SR_ARB_VERIFY_EN (adds CHECK state, Q readback
// compare, single retry, mismatch -> err).
module sr_cmd_arbiter #(
   parameter int  NREQ  = 4,
   parameter int  NBITS = 8,
   localparam int IDXW  = $clog2(NBITS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_op,
   input  logic [NREQ*IDXW-1:0] req_idx,
   output logic [NBITS-1:0]     S,
   output logic [NBITS-1:0]     R,
   input  logic [NBITS-1:0]     Q,
   output logic [NREQ-1:0]      gnt,
   output logic                 busy,
   output logic                 err
);
   localparam int PW = $clog2(NREQ);

`ifdef SR_ARB_VERIFY_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1, CHECK = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DRIVE = 2'd1} state_t;
`endif

   state_t            state, state_d;
   logic [PW-1:0]     ptr, ptr_d;
   logic [PW-1:0]     win_q, win_d;
   logic              op_q, op_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              bad_q, bad_d;     // latched index is out of range
   logic              retry_q, retry_d;
   logic              err_q, err_d;
   logic [NBITS-1:0]  s_q, s_d, r_q, r_d;

   logic [PW-1:0]     win;
   logic              found;
   logic [IDXW-1:0]   sel_idx;
   logic              sel_op;
   int                j;

   // Round-robin pick: first asserted requester scanning from ptr upward.
   always_comb begin
      found = 1'b0;
      win   = '0;
      j     = 0;
      for (int i = 0; i < NREQ; i++) begin
         j = (int'(ptr) + i) % NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            win   = PW'(j);
         end
      end
   end

   assign sel_idx = req_idx[win*IDXW +: IDXW];
   assign sel_op  = req_op[win];

   // Next-state, next S/R drive and the grant pulse.
   always_comb begin
      state_d = state;
      ptr_d   = ptr;
      win_d   = win_q;
      op_d    = op_q;
      idx_d   = idx_q;
      bad_d   = bad_q;
      retry_d = retry_q;
      err_d   = err_q;
      s_d     = '0;
      r_d     = '0;
      gnt     = '0;
      case (state)
         IDLE: begin
            if (found) begin
               win_d   = win;
               op_d    = sel_op;
               idx_d   = sel_idx;
               retry_d = 1'b0;
               ptr_d   = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
               state_d = DRIVE;
               // A bad index still spends the DRIVE cycle (silently) so the
               // grant lands while busy and the held req is not re-taken.
               if (int'(sel_idx) >= NBITS) begin
                  bad_d = 1'b1;
                  err_d = 1'b1;
               end else begin
                  bad_d        = 1'b0;
                  s_d[sel_idx] = sel_op;
                  r_d[sel_idx] = ~sel_op;
               end
            end
         end
         DRIVE: begin
`ifdef SR_ARB_VERIFY_EN
            if (bad_q) begin
               gnt[win_q] = 1'b1;
               state_d    = IDLE;
            end else begin
               state_d = CHECK;
            end
`else
            gnt[win_q] = 1'b1;
            state_d    = IDLE;
`endif
         end
`ifdef SR_ARB_VERIFY_EN
         CHECK: begin
            if (Q[idx_q] == op_q) begin
               gnt[win_q] = 1'b1;
               state_d    = IDLE;
            end else if (!retry_q) begin
               retry_d    = 1'b1;
               s_d[idx_q] = op_q;
               r_d[idx_q] = ~op_q;
               state_d    = DRIVE;
            end else begin
               err_d      = 1'b1;
               gnt[win_q] = 1'b1;
               state_d    = IDLE;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

`ifndef SR_ARB_VERIFY_EN
   // Readback and latched op are only consumed by the verify path.
   logic unused_ok;
   assign unused_ok = ^{Q, op_q, idx_q, retry_q};
`endif

   // State and registered S/R drive; rst clears everything including err.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         win_q   <= '0;
         op_q    <= 1'b0;
         idx_q   <= '0;
         bad_q   <= 1'b0;
         retry_q <= 1'b0;
         err_q   <= 1'b0;
         s_q     <= '0;
         r_q     <= '0;
      end else begin
         state   <= state_d;
         ptr     <= ptr_d;
         win_q   <= win_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         bad_q   <= bad_d;
         retry_q <= retry_d;
         err_q   <= err_d;
         s_q     <= s_d;
         r_q     <= r_d;
      end
   end

   assign S    = s_q;
   assign R    = r_q;
   assign busy = (state != IDLE);
   assign err  = err_q;
endmodule

// File: tb/tb_sr_cmd_arbiter.sv
// Self-checking bench for sr_cmd_arbiter (NREQ=4, NBITS=6) with a modelled
// SR flip-flop bank driving Q.
module tb_sr_cmd_arbiter;
   localparam int NREQ = 4, NBITS = 6, IDXW = 3;
`ifdef SR_ARB_VERIFY_EN
   localparam int L = 2;
   localparam bit VER = 1'b1;
`else
   localparam int L = 1;
   localparam bit VER = 1'b0;
`endif

   logic                 clk, rst;
   logic [NREQ-1:0]      req, req_op, gnt;
   logic [NREQ*IDXW-1:0] req_idx;
   logic [NBITS-1:0]     S, R, Q, qff;
   logic                 busy, err, force_q0;

   sr_cmd_arbiter #(.NREQ(NREQ), .NBITS(NBITS)) dut (
      .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_idx(req_idx),
      .S(S), .R(R), .Q(Q), .gnt(gnt), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Flip-flop bank model.
   initial qff = '0;
   always @(posedge clk) qff <= (qff | S) & ~R;
   assign Q = force_q0 ? '0 : qff;

   int checks = 0, failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Wait (bounded) for a grant, collecting S/R activity and the invariant.
   task automatic wait_gnt(output logic [3:0] g, output int lat, output logic [5:0] sa,
                           output logic [5:0] ra, output int np, output bit inv_ok);
      g = '0; lat = 0; sa = '0; ra = '0; np = 0; inv_ok = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         sa = sa | S;
         ra = ra | R;
         if ((S | R) != '0) np++;
         if ((S & R) != '0 || $countones(S | R) > 1) inv_ok = 1'b0;
         if (gnt != '0) begin
            g = gnt;
            lat = c;
            break;
         end
      end
   endtask

   typedef struct {
      bit          gap;
      logic [3:0]  rq;
      logic [3:0]  op;
      logic [11:0] idx;
      logic [3:0]  eg;
      logic [5:0]  es;
      logic [5:0]  er;
      int          lat;
   } vec_t;

   vec_t        tbl[10];
   logic [3:0]  g;
   logic [5:0]  sa, ra;
   int          lat, np;
   bit          inv_ok;
   logic [11:0] rot;

   initial begin
      rot = {3'd3, 3'd2, 3'd1, 3'd0};
      // rotation with all four held, each sets its own bit
      tbl[0] = '{1'b0, 4'hF, 4'hF, rot, 4'b0001, 6'b000001, 6'b0, L};
      tbl[1] = '{1'b0, 4'hF, 4'hF, rot, 4'b0010, 6'b000010, 6'b0, L+1};
      tbl[2] = '{1'b0, 4'hF, 4'hF, rot, 4'b0100, 6'b000100, 6'b0, L+1};
      tbl[3] = '{1'b0, 4'hF, 4'hF, rot, 4'b1000, 6'b001000, 6'b0, L+1};
      tbl[4] = '{1'b0, 4'hF, 4'hF, rot, 4'b0001, 6'b000001, 6'b0, L+1};
      // single ops from idle
      tbl[5] = '{1'b1, 4'b0100, 4'b0100, 12'h140, 4'b0100, 6'b100000, 6'b0, L};
      tbl[6] = '{1'b1, 4'b0010, 4'b0000, 12'h008, 4'b0010, 6'b0, 6'b000010, L};
      tbl[7] = '{1'b1, 4'b1000, 4'b1000, 12'h000, 4'b1000, 6'b000001, 6'b0, L};
      // fairness: 3 won, so 0 next, then 3 again even with 0 re-requesting
      tbl[8] = '{1'b0, 4'b1001, 4'b1000, 12'h802, 4'b0001, 6'b0, 6'b000100, L+1};
      tbl[9] = '{1'b0, 4'b1001, 4'b1000, 12'h802, 4'b1000, 6'b010000, 6'b0, L+1};

      force_q0 = 1'b0;
      rst = 1'b1; req = 4'hF; req_op = 4'hF; req_idx = rot;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("rst_S", S, 0);
         chk("rst_R", R, 0);
         chk("rst_gnt", gnt, 0);
         chk("rst_busy", busy, 0);
         chk("rst_err", err, 0);
      end
      rst = 1'b0;

      for (int t = 0; t < 10; t++) begin
         if (tbl[t].gap) begin
            req = '0;
            repeat (3) @(negedge clk);
         end
         req = tbl[t].rq; req_op = tbl[t].op; req_idx = tbl[t].idx;
         wait_gnt(g, lat, sa, ra, np, inv_ok);
         $display("vec %0d gnt=%b lat=%0d", t, g, lat);
         chk("tbl_gnt", g, tbl[t].eg);
         chk("tbl_lat", lat, tbl[t].lat);
         chk("tbl_S", sa, tbl[t].es);
         chk("tbl_R", ra, tbl[t].er);
         chk("tbl_inv", inv_ok, 1);
         chk("tbl_err", err, 0);
      end

      // Readback failure: Q stuck at 0 while requester 1 sets bit 3.
      req = '0;
      repeat (3) @(negedge clk);
      force_q0 = 1'b1;
      req = 4'b0010; req_op = 4'b0010; req_idx = 12'h018;
      wait_gnt(g, lat, sa, ra, np, inv_ok);
      req = '0;
      chk("vf_gnt", g, 4'b0010);
      chk("vf_lat", lat, VER ? 4 : 1);
      chk("vf_pulses", np, VER ? 2 : 1);
      chk("vf_S", sa, 6'b001000);
      chk("vf_inv", inv_ok, 1);
      @(negedge clk);
      chk("vf_err", err, VER);
      repeat (3) @(negedge clk);
      chk("vf_err_sticky", err, VER);
      force_q0 = 1'b0;

      // Out-of-range index (idx = NBITS).
      req = 4'b0001; req_op = 4'b0001; req_idx = 12'h006;
      wait_gnt(g, lat, sa, ra, np, inv_ok);
      req = '0;
      chk("oor_gnt", g, 4'b0001);
      chk("oor_lat", lat, 1);
      chk("oor_activity", np, 0);
      chk("oor_err", err, 1);
      repeat (3) @(negedge clk);
      req = 4'b0100; req_op = 4'b0100; req_idx = 12'h140;
      wait_gnt(g, lat, sa, ra, np, inv_ok);
      req = '0;
      chk("oor_next_gnt", g, 4'b0100);
      chk("oor_next_S", sa, 6'b100000);
      chk("err_sticky", err, 1);

      // Reset during DRIVE; held requests re-arbitrate from ptr=0.
      repeat (3) @(negedge clk);
      req = 4'b0001; req_op = 4'b0001; req_idx = 12'h005;
      @(negedge clk);
      chk("rd_S_drive", S, 6'b100000);
      chk("rd_gnt_drive", gnt, VER ? 4'b0000 : 4'b0001);
      rst = 1'b1; req = 4'b0101; req_op = 4'b0001; req_idx = 12'h045;
      @(negedge clk);
      chk("rd_S_clr", S, 0);
      chk("rd_gnt_clr", gnt, 0);
      chk("rd_busy_clr", busy, 0);
      chk("rd_err_clr", err, 0);
      rst = 1'b0;
      // ptr was 1 (requester 0 won last); after reset requester 0 wins again
      wait_gnt(g, lat, sa, ra, np, inv_ok);
      req = '0;
      chk("rd_rearb_gnt", g, 4'b0001);
      chk("rd_rearb_lat", lat, L);
      chk("rd_rearb_S", sa, 6'b100000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
